// File: rtl/mvm_feeder_if.sv
// Operand-feed, result-return and control signals between the MVM feeder and its host/engine.
interface mvm_feeder_if;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        start;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  modport master (
    output ld_en, ld_addr, ld_data, start, out_ready, res_valid, res_data, rd_addr,
    input  out_valid, out_data, res_ready, rd_data, busy, done
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, out_ready, res_valid, res_data, rd_addr,
    output out_valid, out_data, res_ready, rd_data, busy, done
  );
endinterface

// File: rtl/mvm_feeder.sv
// Streams a stored matrix/vector operand set to an MVM engine and captures its K result words.
module mvm_feeder #(
  parameter int unsigned K    = 4,
  parameter int unsigned NOPS = K * K + 2 * K
) (
  input logic          clk,
  input logic          reset,
  mvm_feeder_if.slave  bus
);

  localparam int unsigned PW = $clog2(NOPS);
  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_store [NOPS];
  logic [15:0]     r_result [K];
  logic [PW-1:0]   r_send_ptr;
  logic [RW-1:0]   r_rcv_ptr;
  logic            w_send_xfer;
  logic            w_res_xfer;
  logic            w_ld_ok;
  logic            w_send_last;
  logic            w_res_last;

  assign w_send_xfer = (r_state == SEND) && bus.out_ready;
  assign w_res_xfer  = (r_state == RECV) && bus.res_valid;
  assign w_ld_ok     = (r_state == IDLE) && bus.ld_en && (32'(bus.ld_addr) < NOPS);
  assign w_send_last = (r_send_ptr == PW'(NOPS - 1));
  assign w_res_last  = (r_rcv_ptr == RW'(K - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SEND;
      SEND:    if (w_send_xfer && w_send_last) w_next = RECV;
      RECV:    if (w_res_xfer && w_res_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 8'd0;
    bus.res_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_store[r_send_ptr];
        bus.busy      = 1'b1;
      end
      RECV: begin
        bus.res_ready = 1'b1;
        bus.busy      = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand store survives reset so a job can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (w_ld_ok) r_store[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_send_ptr <= '0;
    end else if (r_state != SEND) begin
      r_send_ptr <= '0;
    end else if (w_send_xfer) begin
      r_send_ptr <= w_send_last ? '0 : r_send_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcv_ptr <= '0;
      for (int i = 0; i < int'(K); i++) r_result[i] <= 16'd0;
    end else if (r_state != RECV) begin
      r_rcv_ptr <= '0;
    end else if (w_res_xfer) begin
      r_result[r_rcv_ptr] <= bus.res_data;
      r_rcv_ptr           <= w_res_last ? '0 : r_rcv_ptr + RW'(1);
    end
  end

  assign bus.rd_data = r_result[bus.rd_addr];

endmodule

// File: tb/tb_mvm_feeder.sv
// Scoreboard bench for mvm_feeder: expected operand bytes queued at start, popped on each engine-side transfer.
module tb_mvm_feeder;

  localparam int NOPS = 24;
  localparam int K    = 4;

  logic clk;
  logic rst_n;
  mvm_feeder_if u_if ();

  mvm_feeder dut (.clk(clk), .reset(rst_n), .bus(u_if.slave));

  int total = 0;
  int bad   = 0;

  logic [7:0]  model [NOPS];
  logic [15:0] res_vals [K];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_e;
  logic [7:0]  prev_data;
  logic        prev_stall;
  int          n_xfer;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Engine-side monitor: scoreboard pop on transfer, stability check after a stall.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (prev_stall) begin
        total++;
        if (u_if.out_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold got=%h exp=%h", u_if.out_data, prev_data);
        end
      end
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_data  = u_if.out_data;
      if (u_if.out_valid && u_if.out_ready) begin
        n_xfer++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte got=%h exp=none", u_if.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (u_if.out_data !== mon_e) begin
            bad++;
            $display("FAIL byte_order got=%h exp=%h", u_if.out_data, mon_e);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load_ops();
    for (int i = 0; i < NOPS; i++) begin
      @(negedge clk);
      u_if.ld_en   = 1'b1;
      u_if.ld_addr = 5'(i);
      u_if.ld_data = model[i];
    end
    @(negedge clk);
    u_if.ld_en = 1'b0;
  endtask

  task automatic check_rd(input string name);
    for (int a = 0; a < K; a++) begin
      u_if.rd_addr = 2'(a);
      #1;
      total++;
      if (u_if.rd_data !== res_vals[a]) begin
        bad++;
        $display("FAIL %s[%0d] got=%h exp=%h", name, a, u_if.rd_data, res_vals[a]);
      end
    end
  endtask

  // pat 0: out_ready always 1; pat 1: 1,0,0 repeating. inject 1: start+ld_en mid-SEND; 2: ld_en with start.
  task automatic run_job(input string name, input int pat, input int gap, input int inject);
    int c;
    bool_loop: begin end
    @(negedge clk);
    u_if.start = 1'b1;
    if (inject == 2) begin
      u_if.ld_en   = 1'b1;
      u_if.ld_addr = 5'd3;
      u_if.ld_data = 8'hA7;
      model[3]     = 8'hA7;
    end
    for (int i = 0; i < NOPS; i++) exp_q.push_back(model[i]);
    n_xfer = 0;
    u_if.out_ready = (pat == 0);
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      u_if.start = 1'b0;
      u_if.ld_en = 1'b0;
      if (c == 1) begin
        total++;
        if (u_if.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL %s_valid_rise got=%b exp=1", name, u_if.out_valid);
        end
      end
      if (u_if.res_ready) break;
      if (c > 300) begin
        bad++;
        total++;
        $display("FAIL %s_send_timeout got=%0d exp<=300", name, c);
        return;
      end
      u_if.out_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      if (inject == 1 && c == 5) begin
        u_if.start   = 1'b1;
        u_if.ld_en   = 1'b1;
        u_if.ld_addr = 5'd0;
        u_if.ld_data = 8'h55;
      end
    end
    u_if.out_ready = 1'b0;
    total++;
    if (u_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid_drop got=%b exp=0", name, u_if.out_valid);
    end
    if (pat == 0) begin
      total++;
      if (c !== NOPS + 1) begin
        bad++;
        $display("FAIL %s_send_cycles got=%0d exp=%0d", name, c, NOPS + 1);
      end
    end
    for (int i = 0; i < K; i++) begin
      for (int g = 0; g < gap; g++) begin
        u_if.res_valid = 1'b0;
        u_if.res_data  = 16'hDEAD;
        @(negedge clk);
        c++;
      end
      u_if.res_valid = 1'b1;
      u_if.res_data  = res_vals[i];
      @(negedge clk);
      c++;
    end
    u_if.res_valid = 1'b0;
    total++;
    if ({u_if.done, u_if.busy, u_if.res_ready} !== 3'b110) begin
      bad++;
      $display("FAIL %s_done_state got=%b exp=110", name, {u_if.done, u_if.busy, u_if.res_ready});
    end
    if (gap == 0) begin
      total++;
      if (c !== NOPS + K + 1) begin
        bad++;
        $display("FAIL %s_latency got=%0d exp=%0d", name, c, NOPS + K + 1);
      end
    end
    @(negedge clk);
    total++;
    if ({u_if.done, u_if.busy} !== 2'b00) begin
      bad++;
      $display("FAIL %s_after_done got=%b exp=00", name, {u_if.done, u_if.busy});
    end
    total++;
    if (n_xfer !== NOPS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_count got=%0d exp=%0d", name, n_xfer, NOPS);
    end
    check_rd({name, "_rd"});
  endtask

  task automatic test_reset();
    for (int a = 0; a < K; a++) res_vals[a] = 16'h0000;
    repeat (2) @(negedge clk);
    total++;
    if ({u_if.out_valid, u_if.res_ready, u_if.busy, u_if.done} !== 4'b0000 || u_if.out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%h exp=0000/00",
               {u_if.out_valid, u_if.res_ready, u_if.busy, u_if.done}, u_if.out_data);
    end
    check_rd("reset_rd");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < NOPS; i++) model[i] = 8'h00;
    for (int r = 0; r < K; r++) model[r * K + r] = 8'h01;
    for (int i = 0; i < K; i++) model[K * K + K + i] = 8'(i + 1);
    load_ops();
    res_vals[0] = 16'h0001; res_vals[1] = 16'h0002;
    res_vals[2] = 16'h0003; res_vals[3] = 16'h0004;
    run_job("basic", 0, 0, 0);
  endtask

  task automatic test_stall_results();
    for (int i = 0; i < NOPS; i++) model[i] = 8'($urandom_range(0, 255));
    load_ops();
    res_vals[0] = 16'h0005; res_vals[1] = 16'hFFFD;
    res_vals[2] = 16'h7FFF; res_vals[3] = 16'h8000;
    run_job("stall", 1, 2, 0);
  endtask

  task automatic test_ignore_busy();
    res_vals[0] = 16'h1111; res_vals[1] = 16'h2222;
    res_vals[2] = 16'h3333; res_vals[3] = 16'h4444;
    run_job("ign1", 0, 1, 1);
    repeat (3) @(negedge clk);
    total++;
    if (u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_restart got=%b exp=0", u_if.busy);
    end
    run_job("ign2", 0, 0, 0);
  endtask

  task automatic test_ld_with_start();
    res_vals[0] = 16'hA000; res_vals[1] = 16'h0B00;
    res_vals[2] = 16'h00C0; res_vals[3] = 16'h000D;
    run_job("ldstart", 0, 0, 2);
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < NOPS; i++) exp_q.push_back(model[i]);
    @(negedge clk);
    u_if.start = 1'b0;
    c = 0;
    while (n_xfer_done_count(c) < 10) begin
      @(negedge clk);
      c++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({u_if.out_valid, u_if.busy} !== 2'b00) begin
      bad++;
      $display("FAIL midreset_async got=%b exp=00", {u_if.out_valid, u_if.busy});
    end
    for (int a = 0; a < K; a++) res_vals[a] = 16'h0000;
    check_rd("midreset_rd");
    exp_q.delete();
    u_if.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    res_vals[0] = 16'h0042; res_vals[1] = 16'hFF00;
    res_vals[2] = 16'h0001; res_vals[3] = 16'h8001;
    run_job("rerun", 0, 0, 0);
  endtask

  function automatic int n_xfer_done_count(input int cyc);
    return cyc;
  endfunction

  initial begin
    rst_n          = 1'b0;
    u_if.ld_en     = 1'b0;
    u_if.ld_addr   = 5'd0;
    u_if.ld_data   = 8'd0;
    u_if.start     = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.res_valid = 1'b0;
    u_if.res_data  = 16'd0;
    u_if.rd_addr   = 2'd0;
    prev_stall     = 1'b0;
    prev_data      = 8'd0;
    n_xfer         = 0;
    test_reset();
    test_basic();
    test_stall_results();
    test_ignore_busy();
    test_ld_with_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvm_feeder.md
MVM_FEEDER -- requirements
Module: mvm_feeder

Interface
REQ-001 Parameter K, default 4: matrix dimension; square matrix, vector lengths K.
REQ-002 Parameter NOPS, default K*K+2*K (24): operand bytes per job.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 ld_en  input  1  operand-load write strobe.
REQ-006 ld_addr  input  5  operand index 0..NOPS-1.
REQ-007 ld_data  input  8  signed operand byte.
REQ-008 start  input  1  single-cycle job start request.
REQ-009 out_valid  output  1  operand byte valid toward the MVM engine.
REQ-010 out_data  output  8  signed operand byte.
REQ-011 out_ready  input  1  engine accepts operand byte.
REQ-012 res_valid  input  1  engine result valid.
REQ-013 res_data  input  16  signed result word.
REQ-014 res_ready  output  1  feeder accepts result.
REQ-015 rd_addr  input  2  result read index.
REQ-016 rd_data  output  16  captured result word.
REQ-017 busy  output  1  job in progress.
REQ-018 done  output  1  one-cycle job-complete pulse.

Function
REQ-019 The operand store shall hold NOPS bytes: index 0..K*K-1 = M row-major, K*K..K*K+K-1 = b, K*K+K..NOPS-1 = x; this is also the send order.
REQ-020 The FSM shall have states IDLE, SEND, RECV, DONE; IDLE->SEND on start; SEND->RECV after the NOPS-th accepted byte; RECV->DONE after the K-th accepted result; DONE->IDLE unconditionally next cycle.
REQ-021 ld_en shall write ld_data to the store at ld_addr only in IDLE; ld_en outside IDLE and ld_addr>=NOPS shall be ignored.
REQ-022 ld_en and start in the same IDLE cycle: the write shall complete and start shall be accepted; the new byte is sent.
REQ-023 start outside IDLE shall be ignored.
REQ-024 In SEND, out_valid shall be 1 and out_data = store[send_ptr]; out_valid shall rise the cycle after start is accepted.
REQ-025 An operand transfer occurs on a cycle with out_valid && out_ready; send_ptr shall then increment by 1.
REQ-026 With out_valid=1 and out_ready=0, out_data and send_ptr shall hold; no byte skipped or duplicated.
REQ-027 out_valid shall be 0 in the cycle after the NOPS-th transfer and in all non-SEND states; send_ptr shall clear to 0 on leaving SEND.
REQ-028 res_ready shall be 1 only in RECV; res_valid outside RECV shall be ignored.
REQ-029 A result transfer (res_valid && res_ready) shall write res_data to result[rcv_ptr], rcv_ptr 0..K-1 incrementing; rcv_ptr clears on leaving RECV.
REQ-030 res_ready shall be 0 in the cycle after the K-th result transfer.
REQ-031 done shall be 1 for exactly the one DONE cycle; busy shall be 1 in SEND, RECV, DONE.
REQ-032 rd_data shall equal result[rd_addr] combinationally; results held until overwritten by the next job.
REQ-033 Minimum job latency with out_ready=res_valid=1 throughout: start accepted at cycle 0, bytes sent cycles 1..NOPS, results captured cycles NOPS+1..NOPS+K, done at NOPS+K+1.

Reset
REQ-034 While reset=0: state IDLE, out_valid=0, out_data=0, res_ready=0, busy=0, done=0, send_ptr=rcv_ptr=0, all result words 0, rd_data=0.
REQ-035 Reset assertion mid-job shall take effect asynchronously, without waiting for a clock edge; operand store contents are not cleared.
REQ-036 After reset release, the next start shall send from index 0.

Verification
REQ-037 Load M=identity, b=0, x=[1,2,3,4]; start; out_ready=1 -> 24 bytes in 24 consecutive cycles in index order, then res_ready=1.
REQ-038 out_ready toggling 1,0,0,1,... during SEND -> out_data stable while stalled; engine-side log equals store order, count exactly 24.
REQ-039 Results 16'h0005, 16'hFFFD, 16'h7FFF, 16'h8000 with res_valid gaps -> rd_addr 0..3 returns these values; done high exactly one cycle; busy low next cycle.
REQ-040 start pulse and ld_en (addr 0, data 8'h55) during SEND -> no restart, store[0] unchanged on next job.
REQ-041 Assert reset after 10 transfers -> out_valid, busy drop immediately; results read 0; new start resends from index 0 with original operands.
